// File: rtl/tone_decoder.sv
// Tone period / high-time meter: synchronizes a square wave, times rising-edge spacing,
// rejects glitch periods, detects a stable (locked) tone and flags loss of signal.
module tone_decoder #(
    parameter int unsigned   BW         = 24,
    parameter logic [BW-1:0] MIN_PERIOD = 24'd4,
    parameter logic [BW-1:0] TIMEOUT    = 24'd2400000,
    parameter logic [BW-1:0] TOL        = 24'd2,
    parameter logic [7:0]    LOCK_N     = 8'd4
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          en_i,
    input  logic          tone_i,
    output logic [BW-1:0] period_o,
    output logic [BW-1:0] high_o,
    output logic          valid_o,
    output logic          lock_o,
    output logic          timeout_o
);

    typedef enum logic {
        WAIT_RISE = 1'b0,
        MEASURE   = 1'b1
    } state_e;

    state_e state_q, state_d;

    // [0],[1] form the synchronizer, [2] is the history sample used for edge detection
    logic [2:0]    sync_q;
    logic          rise_q;
    logic          fall_q;

    logic [BW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] hi_q, hi_d;
    logic [BW-1:0] period_q, period_d;
    logic [BW-1:0] high_q, high_d;
    logic          valid_q, valid_d;
    logic          lock_q, lock_d;
    logic          timeout_q, timeout_d;
    logic [7:0]    match_q, match_d;
    logic          have_prev_q, have_prev_d;

    logic [BW-1:0] cnt_inc;
    logic [BW-1:0] diff;
    logic          timeout_hit;
    logic          accept;
    logic          is_match;

    // The candidate period is cnt+1, so rising edges P cycles apart measure exactly P.
    assign cnt_inc     = cnt_q + {{(BW-1){1'b0}}, 1'b1};
    assign timeout_hit = (cnt_inc >= TIMEOUT);
    assign accept      = (cnt_inc >= MIN_PERIOD);
    assign diff        = (cnt_inc >= period_q) ? (cnt_inc - period_q) : (period_q - cnt_inc);
    assign is_match    = have_prev_q && (diff <= TOL);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= WAIT_RISE;
            sync_q      <= 3'b000;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            cnt_q       <= '0;
            hi_q        <= '0;
            period_q    <= '0;
            high_q      <= '0;
            valid_q     <= 1'b0;
            lock_q      <= 1'b0;
            timeout_q   <= 1'b0;
            match_q     <= 8'd0;
            have_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[1:0], tone_i};
            rise_q      <= sync_q[1] & ~sync_q[2];
            fall_q      <= ~sync_q[1] & sync_q[2];
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            period_q    <= period_d;
            high_q      <= high_d;
            valid_q     <= valid_d;
            lock_q      <= lock_d;
            timeout_q   <= timeout_d;
            match_q     <= match_d;
            have_prev_q <= have_prev_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en_i) begin
            state_d = WAIT_RISE;
        end else begin
            case (state_q)
                WAIT_RISE: if (rise_q) state_d = MEASURE;
                MEASURE:   if (!rise_q && timeout_hit) state_d = WAIT_RISE;
                default:   state_d = WAIT_RISE;
            endcase
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        period_d    = period_q;
        high_d      = high_q;
        valid_d     = 1'b0;
        lock_d      = lock_q;
        timeout_d   = timeout_q;
        match_d     = match_q;
        have_prev_d = have_prev_q;

        if (!en_i) begin
            cnt_d       = '0;
            hi_d        = '0;
            lock_d      = 1'b0;
            timeout_d   = 1'b0;
            match_d     = 8'd0;
            have_prev_d = 1'b0;
        end else if (state_q == WAIT_RISE) begin
            if (rise_q) begin
                cnt_d = '0;
            end
        end else begin
            cnt_d = (cnt_q >= TIMEOUT) ? TIMEOUT : cnt_inc;
            if (fall_q) begin
                hi_d = cnt_inc;
            end
            // A rising edge takes priority over a simultaneous timeout.
            if (rise_q) begin
                cnt_d = '0;
                if (accept) begin
                    period_d    = cnt_inc;
                    high_d      = hi_q;
                    valid_d     = 1'b1;
                    timeout_d   = 1'b0;
                    have_prev_d = 1'b1;
                    if (is_match) begin
                        match_d = (match_q >= LOCK_N) ? LOCK_N : (match_q + 8'd1);
                    end else begin
                        match_d = 8'd0;
                    end
                    lock_d = (match_d == LOCK_N);
                end else begin
                    match_d = 8'd0;
                    lock_d  = 1'b0;
                end
            end else if (timeout_hit) begin
                timeout_d   = 1'b1;
                lock_d      = 1'b0;
                match_d     = 8'd0;
                have_prev_d = 1'b0;
            end
        end
    end

    assign period_o  = period_q;
    assign high_o    = high_q;
    assign valid_o   = valid_q;
    assign lock_o    = lock_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder: drives cycle-exact square waves and checks recorded valid_o events.
module tb_tone_decoder;
    localparam int TO = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        tone = 1'b0;
    logic [23:0] period;
    logic [23:0] high;
    logic        valid;
    logic        lock;
    logic        tmo;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int          v_cyc[$];
    logic [23:0] v_per[$];
    logic [23:0] v_hi[$];
    logic        v_lock[$];
    logic        v_to[$];
    int          r_cyc[$];

    tone_decoder #(.TIMEOUT(24'd1000)) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .en_i     (en),
        .tone_i   (tone),
        .period_o (period),
        .high_o   (high),
        .valid_o  (valid),
        .lock_o   (lock),
        .timeout_o(tmo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            v_cyc.push_back(cyc);
            v_per.push_back(period);
            v_hi.push_back(high);
            v_lock.push_back(lock);
            v_to.push_back(tmo);
            $display("valid: cyc=%0d period=%0d high=%0d lock=%0b timeout=%0b", cyc, period, high, lock, tmo);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wave(input int per, input int hi);
        tone = 1'b1;
        r_cyc.push_back(cyc);
        tick(hi);
        tone = 1'b0;
        tick(per - hi);
    endtask

    task automatic close_tone();
        tone = 1'b1;
        r_cyc.push_back(cyc);
        tick(1);
        tone = 1'b0;
        tick(8);
    endtask

    task automatic clear();
        tone = 1'b0;
        en = 1'b0;
        tick(4);
        en = 1'b1;
        tick(4);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1;
        tone = 1'b0;
        tick(3);
        total++;
        if ({period, high, valid, lock, tmo} !== 51'd0) begin
            bad++;
            $display("FAIL reset_outputs: got p=%0d h=%0d v=%0b l=%0b t=%0b want all 0", period, high, valid, lock, tmo);
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_basic();
        int b;
        int r;
        clear();
        b = v_cyc.size();
        r = r_cyc.size();
        repeat (5) wave(125, 62);
        close_tone();
        total++;
        if (v_cyc.size() - b !== 5) begin
            bad++; $display("FAIL basic_count: got %0d want 5", v_cyc.size() - b);
        end
        total++;
        if (v_per[b] !== 24'd125 || v_hi[b] !== 24'd62) begin
            bad++; $display("FAIL basic_first: got p=%0d h=%0d want p=125 h=62", v_per[b], v_hi[b]);
        end
        total++;
        if (v_cyc[b] - r_cyc[r+1] !== 4) begin
            bad++; $display("FAIL basic_latency: got %0d want 4", v_cyc[b] - r_cyc[r+1]);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (v_cyc[b+i+1] - v_cyc[b+i] !== 125) begin
                bad++; $display("FAIL basic_spacing%0d: got %0d want 125", i, v_cyc[b+i+1] - v_cyc[b+i]);
            end
        end
        total++;
        if (v_lock[b+3] !== 1'b0 || v_lock[b+4] !== 1'b1) begin
            bad++; $display("FAIL basic_lock: got 4th=%0b 5th=%0b want 0 1", v_lock[b+3], v_lock[b+4]);
        end
    endtask

    task automatic test_change();
        int b;
        clear();
        b = v_cyc.size();
        repeat (5) wave(125, 62);
        repeat (5) wave(128, 64);
        close_tone();
        total++;
        if (v_cyc.size() - b !== 10) begin
            bad++; $display("FAIL change_count: got %0d want 10", v_cyc.size() - b);
        end
        total++;
        if (v_lock[b+4] !== 1'b1) begin
            bad++; $display("FAIL change_prelock: got %0b want 1", v_lock[b+4]);
        end
        total++;
        if (v_per[b+5] !== 24'd128 || v_hi[b+5] !== 24'd64 || v_lock[b+5] !== 1'b0) begin
            bad++; $display("FAIL change_jump: got p=%0d h=%0d l=%0b want p=128 h=64 l=0", v_per[b+5], v_hi[b+5], v_lock[b+5]);
        end
        total++;
        if (v_lock[b+8] !== 1'b0 || v_lock[b+9] !== 1'b1) begin
            bad++; $display("FAIL change_relock: got 9th=%0b 10th=%0b want 0 1", v_lock[b+8], v_lock[b+9]);
        end
    endtask

    task automatic test_tolerance();
        int b;
        clear();
        b = v_cyc.size();
        wave(125, 62); wave(127, 62); wave(125, 62); wave(127, 62); wave(125, 62);
        close_tone();
        total++;
        if (v_lock[b+3] !== 1'b0 || v_lock[b+4] !== 1'b1 || v_per[b+3] !== 24'd127) begin
            bad++; $display("FAIL tol_in: got l4=%0b l5=%0b p4=%0d want 0 1 127", v_lock[b+3], v_lock[b+4], v_per[b+3]);
        end
        clear();
        b = v_cyc.size();
        repeat (3) begin
            wave(125, 62);
            wave(128, 62);
        end
        close_tone();
        total++;
        if (v_cyc.size() - b !== 6) begin
            bad++; $display("FAIL tol_out_count: got %0d want 6", v_cyc.size() - b);
        end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (v_lock[b+i] !== 1'b0) begin
                bad++; $display("FAIL tol_out_lock%0d: got %0b want 0", i, v_lock[b+i]);
            end
        end
    endtask

    task automatic test_timeout();
        int b;
        int c;
        clear();
        repeat (5) wave(125, 62);
        tone = 1'b1;
        c = cyc;
        tick(62);
        tone = 1'b0;
        while (cyc < c + 3 + TO) @(negedge clk);
        total++;
        if (tmo !== 1'b0 || lock !== 1'b1) begin
            bad++; $display("FAIL timeout_early: got t=%0b l=%0b want t=0 l=1", tmo, lock);
        end
        tick(1);
        total++;
        if (tmo !== 1'b1 || lock !== 1'b0 || period !== 24'd125) begin
            bad++; $display("FAIL timeout_set: got t=%0b l=%0b p=%0d want t=1 l=0 p=125", tmo, lock, period);
        end
        b = v_cyc.size();
        wave(125, 62);
        total++;
        if (tmo !== 1'b1 || v_cyc.size() !== b) begin
            bad++; $display("FAIL timeout_arm: got t=%0b new_valids=%0d want t=1 0", tmo, v_cyc.size() - b);
        end
        wave(125, 62);
        close_tone();
        total++;
        if (v_cyc.size() - b !== 2 || v_to[b] !== 1'b0 || v_lock[b] !== 1'b0 || v_per[b] !== 24'd125) begin
            bad++; $display("FAIL timeout_resume: got n=%0d t=%0b l=%0b p=%0d want 2 0 0 125", v_cyc.size() - b, v_to[b], v_lock[b], v_per[b]);
        end
    endtask

    task automatic test_glitch();
        int b;
        clear();
        b = v_cyc.size();
        repeat (5) wave(125, 62);
        tone = 1'b1; tick(1);
        tone = 1'b0; tick(2);
        tone = 1'b1; tick(20);
        total++;
        if (lock !== 1'b0 || period !== 24'd125 || high !== 24'd62 || v_cyc.size() - b !== 5) begin
            bad++; $display("FAIL glitch_drop: got l=%0b p=%0d h=%0d n=%0d want 0 125 62 5", lock, period, high, v_cyc.size() - b);
        end
        total++;
        if (v_lock[b+4] !== 1'b1) begin
            bad++; $display("FAIL glitch_prelock: got %0b want 1", v_lock[b+4]);
        end
        tick(42);
        tone = 1'b0;
        tick(63);
        wave(125, 62);
        close_tone();
        total++;
        if (v_per[b+5] !== 24'd125 || v_hi[b+5] !== 24'd62 || v_lock[b+5] !== 1'b0 || v_cyc[b+5] - v_cyc[b+4] !== 128) begin
            bad++; $display("FAIL glitch_after: got p=%0d h=%0d l=%0b gap=%0d want 125 62 0 128", v_per[b+5], v_hi[b+5], v_lock[b+5], v_cyc[b+5] - v_cyc[b+4]);
        end
    endtask

    task automatic test_constant();
        int b;
        clear();
        b = v_cyc.size();
        tone = 1'b1;
        tick(300);
        tone = 1'b0;
        tick(10);
        total++;
        if (v_cyc.size() !== b || tmo !== 1'b0) begin
            bad++; $display("FAIL constant_tone: got n=%0d t=%0b want 0 0", v_cyc.size() - b, tmo);
        end
    endtask

    task automatic test_enable();
        int b;
        clear();
        repeat (6) wave(125, 62);
        total++;
        if (lock !== 1'b1) begin
            bad++; $display("FAIL enable_prelock: got %0b want 1", lock);
        end
        en = 1'b0;
        tick(1);
        total++;
        if (valid !== 1'b0 || lock !== 1'b0 || tmo !== 1'b0 || period !== 24'd125 || high !== 24'd62) begin
            bad++; $display("FAIL enable_clear: got v=%0b l=%0b t=%0b p=%0d h=%0d want 0 0 0 125 62", valid, lock, tmo, period, high);
        end
        tick(9);
        en = 1'b1;
        b = v_cyc.size();
        wave(125, 62);
        wave(125, 62);
        close_tone();
        total++;
        if (v_cyc.size() - b !== 2 || v_lock[b] !== 1'b0 || v_lock[b+1] !== 1'b0 || v_per[b] !== 24'd125) begin
            bad++; $display("FAIL enable_restart: got n=%0d l0=%0b l1=%0b p=%0d want 2 0 0 125", v_cyc.size() - b, v_lock[b], v_lock[b+1], v_per[b]);
        end
    endtask

    task automatic test_reset_mid();
        int b;
        clear();
        repeat (3) wave(125, 62);
        tone = 1'b1; tick(62);
        tone = 1'b0; tick(30);
        total++;
        if (period !== 24'd125) begin
            bad++; $display("FAIL rstmid_pre: got p=%0d want 125", period);
        end
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({period, high, valid, lock, tmo} !== 51'd0) begin
            bad++; $display("FAIL rstmid_async: got p=%0d h=%0d v=%0b l=%0b t=%0b want all 0", period, high, valid, lock, tmo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        b = v_cyc.size();
        tick(33);
        wave(125, 62);
        wave(125, 62);
        close_tone();
        total++;
        if (v_cyc.size() - b !== 2 || v_per[b] !== 24'd125 || v_hi[b] !== 24'd62) begin
            bad++; $display("FAIL rstmid_restart: got n=%0d p=%0d h=%0d want 2 125 62", v_cyc.size() - b, v_per[b], v_hi[b]);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_change();
        test_tolerance();
        test_timeout();
        test_glitch();
        test_constant();
        test_enable();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
